reg_write_arbiter: RTL
======================

# reg_write_arbiter

Round-robin write-port arbiter and sequencer for the general-purpose register bank built from 16-bit `Register` instances. Several requesters (ALU writeback, memory load, PC/AR update) present register operations. The block grants one per cycle and drives the bank's shared `I`/`FunSel` bus plus a one-hot enable vector. It also sequences "split" 16-bit loads that arrive over an 8-bit path into two byte beats (low, then high) using the register's write-low-only and write-high-only functions.

## Interface
- `NREQ`, 3, number of requesters (2..4)
- `NREG`, 4, number of registers in the bank (power of two)
- `SW`, $clog2(NREG), register-select width (derived)
- `Clock`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `ReqValid`  in  NREQ  request pending, per requester
- `ReqReady`  out  NREQ  one-hot accept; a transfer occurs when `ReqValid[k] & ReqReady[k]`
- `ReqSel`  in  NREQ*SW  destination register index, slice k
- `ReqFunSel`  in  NREQ*3  register function code, slice k (ignored when split)
- `ReqSplit`  in  NREQ  1 = two-beat byte load of `ReqData`
- `ReqData`  in  NREQ*16  operand, slice k
- `RegE`  out  NREG  one-hot enable to bank
- `RegFunSel`  out  3  function code to bank
- `RegI`  out  16  data to bank
- `Busy`  out  1  high while any beat is being driven
- `GrantId`  out  2  index of requester owning the current beat

## Operation
- States: IDLE (nothing driven), ISSUE (single op driven), LOW (split low beat driven), HIGH (split high beat driven).
- Arbitration is combinational over `ReqValid` and a round-robin pointer `ptr`. Search order is ptr, ptr+1, … mod NREQ.
- After granting k, `ptr` becomes (k+1) mod NREQ. `ptr` resets to 0.
- Acceptance is permitted in every state except LOW. In LOW, `ReqReady` is all-zero regardless of `ReqValid`.
- Transitions:
  - accept non-split → ISSUE
  - accept split → LOW
  - LOW → HIGH unconditionally
  - IDLE/ISSUE/HIGH with no accept → IDLE
- Beat contents are latched from the accepted slice at acceptance:
  - ISSUE: `RegFunSel` = ReqFunSel, `RegI` = ReqData (all 8 codes pass through unmodified).
  - LOW: `RegFunSel` = 3'b101, `RegI` = {8'h00, ReqData[7:0]}.
  - HIGH: `RegFunSel` = 3'b110, `RegI` = {8'h00, ReqData[15:8]}.
- `RegE` = one-hot(Sel) in ISSUE/LOW/HIGH and 0 in IDLE.
- `Busy` = state≠IDLE. `GrantId` holds the owning requester index, and holds its last value in IDLE.
- The `ptr` update, state and all bank outputs are registered. No combinational path exists from requester inputs to `Reg*` outputs.

## Timing
- Reset (asynchronous assert, synchronous release edge irrelevant to outputs):
  - state = IDLE, `ptr` = 0
  - `RegE` = 0, `RegFunSel` = 3'b000, `RegI` = 0
  - `Busy` = 0, `GrantId` = 0
- Reset during LOW or HIGH drops the pending beat. The accepted request is lost and is not replayed.
- Latency: accept at edge n → beat driven during cycle n+1 → register updates at edge n+2. A split request drives beats in cycles n+1 and n+2.
- Throughput:
  - non-split: 1 op/cycle, back-to-back, with no IDLE bubble
  - split: 2 cycles, next acceptance allowed in the HIGH cycle
- `ReqReady` may assert in the same cycle `ReqValid` rises. Requesters must hold their slice stable while `ReqValid` is high and unaccepted.
- Simultaneous requests: exactly one is granted per cycle. A continuously valid requester waits at most NREQ−1 grants.
- Two consecutive beats to the same register are legal. The bank sees them in order.

## Structure
- Shared package `regbank_pkg`:
  - FunSel encodings (DEC=000, INC=001, LOAD=010, CLR=011, WLOW_CLR=100, WLOW=101, WHIGH=110, SEXT=111)
  - state enum
  - `NREG` default
- Sub-module `rr_pick`: combinational round-robin picker, (valid vector, ptr) → one-hot grant and index. It is reused later by the memory-port arbiter.

## Test plan
- Reset with all `ReqValid`=1 → all outputs 0, `ReqReady`=0 while `Reset`=0. First grant after release is requester 0.
- Requester 1 issues Sel=2, FunSel=010, Data=16'hBEEF:
  - `ReqReady`=3'b010 that cycle
  - next cycle `RegE`=4'b0100, `RegFunSel`=010, `RegI`=16'hBEEF, `GrantId`=1
  - next cycle IDLE, `RegE`=0
- All three requesters valid continuously, non-split → grant order 0,1,2,0,1,2. `RegE` is asserted every cycle with no gaps.
- Split from requester 0, Data=16'h12AB, Sel=3:
  - beat 1: `RegFunSel`=101, `RegI`=16'h00AB, `RegE`=4'b1000
  - beat 2: `RegFunSel`=110, `RegI`=16'h0012
  - `ReqReady`=0 during beat 1, even with requester 2 valid
  - requester 2 accepted during beat 2
- Reset asserted in the LOW cycle of a split → HIGH beat never appears, `RegE`=0 immediately, state IDLE after release.
- Requester 2 valid alone with `ptr`=0, then requesters 0 and 2 valid → 2 granted first, then 0. Checks pointer wrap past NREQ−1.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the general-purpose register bank and its write-port arbiter.
package regbank_pkg;

  localparam int NREG_DEF = 4;
  localparam int GIDW     = 2;

  typedef enum logic [2:0] {
    FS_DEC      = 3'b000,
    FS_INC      = 3'b001,
    FS_LOAD     = 3'b010,
    FS_CLR      = 3'b011,
    FS_WLOW_CLR = 3'b100,
    FS_WLOW     = 3'b101,
    FS_WHIGH    = 3'b110,
    FS_SEXT     = 3'b111
  } funsel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_LOW   = 2'd2,
    ST_HIGH  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && valid[j] && (j >= int'(ptr))) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for the register bank; splits byte loads into low/high beats.
//   state    | meaning
//   ST_IDLE  | nothing driven to the bank
//   ST_ISSUE | single operation driven
//   ST_LOW   | split load, low byte beat driven (no acceptance)
//   ST_HIGH  | split load, high byte beat driven
module reg_write_arbiter
  import regbank_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int NREG = NREG_DEF,
  parameter int SW   = $clog2(NREG)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NREQ-1:0]    ReqValid,
  output logic [NREQ-1:0]    ReqReady,
  input  logic [NREQ*SW-1:0] ReqSel,
  input  logic [NREQ*3-1:0]  ReqFunSel,
  input  logic [NREQ-1:0]    ReqSplit,
  input  logic [NREQ*16-1:0] ReqData,
  output logic [NREG-1:0]    RegE,
  output logic [2:0]         RegFunSel,
  output logic [15:0]        RegI,
  output logic               Busy,
  output logic [GIDW-1:0]    GrantId
);

  arb_state_e         state_q, state_d;
  logic [GIDW-1:0]    ptr_q, ptr_d;
  logic [GIDW-1:0]    gid_q, gid_d;
  logic [7:0]         hi_q, hi_d;
  logic [NREG-1:0]    rege_q, rege_d;
  logic [2:0]         fs_q, fs_d;
  logic [15:0]        regi_q, regi_d;

  logic [NREQ-1:0]    grant;
  logic [GIDW-1:0]    pick_idx;
  logic               pick_any;
  logic               accept;

  logic [SW-1:0]      sel_k;
  logic [2:0]         fs_k;
  logic [15:0]        data_k;
  logic               split_k;

  rr_pick #(.N(NREQ), .IW(GIDW)) u_pick (
    .valid (ReqValid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Held off while in reset so requesters never see a phantom accept.
  assign accept   = Reset && (state_q != ST_LOW) && pick_any;
  assign ReqReady = accept ? grant : '0;

  always_comb begin
    sel_k   = '0;
    fs_k    = '0;
    data_k  = '0;
    split_k = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_k   = ReqSel[k*SW +: SW];
        fs_k    = ReqFunSel[k*3 +: 3];
        data_k  = ReqData[k*16 +: 16];
        split_k = ReqSplit[k];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      hi_q    <= '0;
      rege_q  <= '0;
      fs_q    <= '0;
      regi_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      hi_q    <= hi_d;
      rege_q  <= rege_d;
      fs_q    <= fs_d;
      regi_q  <= regi_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (accept) begin
      state_d = split_k ? ST_LOW : ST_ISSUE;
    end else if (state_q == ST_LOW) begin
      state_d = ST_HIGH;
    end
  end

  // Computes the beat for the next cycle; the registers above present it to the bank.
  always_comb begin
    ptr_d  = ptr_q;
    gid_d  = gid_q;
    hi_d   = hi_q;
    rege_d = '0;
    fs_d   = FS_DEC;
    regi_d = '0;
    if (accept) begin
      gid_d  = pick_idx;
      ptr_d  = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
      rege_d = NREG'(1) << sel_k;
      if (split_k) begin
        fs_d   = FS_WLOW;
        regi_d = {8'h00, data_k[7:0]};
        hi_d   = data_k[15:8];
      end else begin
        fs_d   = fs_k;
        regi_d = data_k;
      end
    end else if (state_q == ST_LOW) begin
      rege_d = rege_q;
      fs_d   = FS_WHIGH;
      regi_d = {8'h00, hi_q};
    end
  end

  assign RegE      = rege_q;
  assign RegFunSel = fs_q;
  assign RegI      = regi_q;
  assign Busy      = (state_q != ST_IDLE);
  assign GrantId   = gid_q;

endmodule
